vga_timing_gen: RTL and testbench

- Raster timing source that drives the DrawX/DrawY/blank inputs of every picture mapper and the monitor's hs/vs pins.
- Free-running horizontal and vertical counters, default 640x480@60 at a 25 MHz vga_clk.
- Sync outputs are delayed by a parameterised pipeline so they stay aligned with mapper colour output, which trails DrawX/DrawY by 2 cycles (1 for ROM read, 1 for colour register).

---
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters, blank, frame pulse and delayed syncs.
// Define VGA_FRAME_CNT_EN to build the 16-bit frame counter behind frame_count.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  L_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  L_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] L_H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] L_V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] L_HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] L_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] L_VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] L_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counters");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE_DELAY must be 0..7");
  end

  logic [9:0]          r_x;
  logic [9:0]          r_y;
  logic                r_blank;
  logic                r_fs;
  logic [PIPE_DELAY:0] r_hs;
  logic [PIPE_DELAY:0] r_vs;

  logic        w_x_last;
  logic        w_y_last;
  logic [9:0]  w_x_nxt;
  logic [9:0]  w_y_nxt;
  logic [10:0] w_xw;
  logic [10:0] w_yw;
  logic        w_blank_nxt;
  logic        w_fs_nxt;
  logic        w_hs_nxt;
  logic        w_vs_nxt;

  // All decodes use the post-edge count so they line up with DrawX/DrawY
  always_comb begin
    w_x_last = (r_x == L_H_LAST);
    w_y_last = (r_y == L_V_LAST);
    w_x_nxt  = w_x_last ? 10'd0 : r_x + 10'd1;
    w_y_nxt  = r_y;
    if (w_x_last) begin
      w_y_nxt = w_y_last ? 10'd0 : r_y + 10'd1;
    end
    w_xw        = {1'b0, w_x_nxt};
    w_yw        = {1'b0, w_y_nxt};
    w_blank_nxt = (w_xw < L_H_ACT) && (w_yw < L_V_ACT);
    w_fs_nxt    = (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
    w_hs_nxt    = !((w_xw >= L_HS_BEG) && (w_xw < L_HS_END));
    w_vs_nxt    = !((w_yw >= L_VS_BEG) && (w_yw < L_VS_END));
  end

  // Stage 0 of each sync line is aligned with DrawX; higher stages add delay
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_blank <= 1'b0;
      r_fs    <= 1'b0;
      r_hs    <= '1;
      r_vs    <= '1;
    end else begin
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_blank <= w_blank_nxt;
      r_fs    <= w_fs_nxt;
      r_hs[0] <= w_hs_nxt;
      r_vs[0] <= w_vs_nxt;
      for (int i = 1; i <= PIPE_DELAY; i++) begin
        r_hs[i] <= r_hs[i-1];
        r_vs[i] <= r_vs[i-1];
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_fcnt;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fcnt <= '0;
    end else if (w_fs_nxt) begin
      r_fcnt <= r_fcnt + 16'd1;
    end
  end

  assign frame_count = r_fcnt;
`else
  assign frame_count = 16'h0000;
`endif

  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign blank       = r_blank;
  assign hs          = r_hs[PIPE_DELAY];
  assign vs          = r_vs[PIPE_DELAY];
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-timing instance plus a miniature raster instance,
// both checked cycle by cycle against a queued reference model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        b;
    logic        h;
    logic        v;
    logic        f;
    logic [15:0] c;
  } obs_t;

`ifdef VGA_FRAME_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        vga_clk;
  logic        reset_n;

  logic [9:0]  dx0, dy0, dx1, dy1;
  logic        bl0, hs0, vs0, fs0;
  logic        bl1, hs1, vs1, fs1;
  logic [15:0] fc0, fc1;

  vga_timing_gen u_dflt (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (dx0),
    .DrawY       (dy0),
    .blank       (bl0),
    .hs          (hs0),
    .vs          (vs0),
    .frame_start (fs0),
    .frame_count (fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE   (16),
    .H_FP       (2),
    .H_SYNC     (4),
    .H_BP       (3),
    .V_ACTIVE   (12),
    .V_FP       (2),
    .V_SYNC     (2),
    .V_BP       (3),
    .PIPE_DELAY (3)
  ) u_small (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (dx1),
    .DrawY       (dy1),
    .blank       (bl1),
    .hs          (hs1),
    .vs          (vs1),
    .frame_start (fs1),
    .frame_count (fc1)
  );

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  int n_tests = 0;
  int n_fail  = 0;

  int ht[2], ha[2], hsb[2], hse[2];
  int vt[2], va[2], vsb[2], vse[2];
  int pd[2];

  int          mx[2], my[2];
  logic        mb[2], mf[2];
  logic [15:0] mc[2];
  logic [7:0]  mhh[2], mvh[2];

  obs_t sb0[$];
  obs_t sb1[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i]  = 0;
      my[i]  = 0;
      mb[i]  = 1'b0;
      mf[i]  = 1'b0;
      mc[i]  = 16'h0;
      mhh[i] = 8'hFF;
      mvh[i] = 8'hFF;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (mx[i] == ht[i] - 1) begin
        mx[i] = 0;
        my[i] = (my[i] == vt[i] - 1) ? 0 : my[i] + 1;
      end else begin
        mx[i] = mx[i] + 1;
      end
      mb[i] = (mx[i] < ha[i]) && (my[i] < va[i]);
      mf[i] = (mx[i] == 0) && (my[i] == 0);
      if (mf[i] && CNT_EN) mc[i] = mc[i] + 16'd1;
      mhh[i] = {mhh[i][6:0], !(mx[i] >= hsb[i] && mx[i] < hse[i])};
      mvh[i] = {mvh[i][6:0], !(my[i] >= vsb[i] && my[i] < vse[i])};
    end
  endtask

  function automatic obs_t exp_of(input int i);
    obs_t e;
    e.x = 10'(mx[i]);
    e.y = 10'(my[i]);
    e.b = mb[i];
    e.h = mhh[i][pd[i]];
    e.v = mvh[i][pd[i]];
    e.f = mf[i];
    e.c = mc[i];
    return e;
  endfunction

  function automatic obs_t obs_of(input int i);
    obs_t o;
    if (i == 0) begin
      o.x = dx0; o.y = dy0; o.b = bl0; o.h = hs0;
      o.v = vs0; o.f = fs0; o.c = fc0;
    end else begin
      o.x = dx1; o.y = dy1; o.b = bl1; o.h = hs1;
      o.v = vs1; o.f = fs1; o.c = fc1;
    end
    return o;
  endfunction

  task automatic step();
    obs_t e0, e1;
    @(posedge vga_clk);
    model_edge();
    sb0.push_back(exp_of(0));
    sb1.push_back(exp_of(1));
    @(negedge vga_clk);
    e0 = sb0.pop_front();
    e1 = sb1.pop_front();
    chk("sb_dflt", 64'(obs_of(0)), 64'(e0));
    chk("sb_small", 64'(obs_of(1)), 64'(e1));
  endtask

  task automatic chk_small_reset(input string tag);
    chk({tag, "_x"},  64'(dx1), 64'(0));
    chk({tag, "_y"},  64'(dy1), 64'(0));
    chk({tag, "_bl"}, 64'(bl1), 64'(0));
    chk({tag, "_hs"}, 64'(hs1), 64'(1));
    chk({tag, "_vs"}, 64'(vs1), 64'(1));
    chk({tag, "_fs"}, 64'(fs1), 64'(0));
    chk({tag, "_fc"}, 64'(fc1), 64'(0));
    chk({tag, "_dflt"}, 64'(obs_of(0)), 64'(exp_of(0)));
  endtask

  int x656, hsf, hs_low, hs_low_s;
  int blank_cnt, vs_low, vsf, y14;
  int fs_cnt, fs_first, fs_second;
  bit found;

  initial begin
    ht  = '{800, 25};  ha  = '{640, 16};
    hsb = '{656, 18};  hse = '{752, 22};
    vt  = '{525, 19};  va  = '{480, 12};
    vsb = '{490, 14};  vse = '{492, 16};
    pd  = '{2, 3};
    x656 = -1; hsf = -1; hs_low = 0; hs_low_s = 0;
    blank_cnt = 0; vs_low = 0; vsf = -1; y14 = -1;
    fs_cnt = 0; fs_first = -1; fs_second = -1;

    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge vga_clk);
    chk_small_reset("reset");

    reset_n = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      step();
      if (k <= 800) begin
        if (dx0 == 10'd656 && x656 < 0) x656 = k;
        if (!hs0 && hsf < 0) hsf = k;
        if (!hs0) hs_low++;
        if (dx0 == 10'd640) chk("blank_x640", 64'(bl0), 64'(0));
      end
      if (k <= 475) begin
        if (bl1) blank_cnt++;
        if (!vs1) vs_low++;
        if (!vs1 && vsf < 0) vsf = k;
        if (dx1 == 10'd0 && dy1 == 10'd14 && y14 < 0) y14 = k;
      end
      if (k <= 25 && !hs1) hs_low_s++;
      if (fs1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
        chk("fs_origin", 64'({dx1, dy1}), 64'(0));
      end
      if (dx1 == 10'd15 && dy1 == 10'd11) chk("blank_15_11", 64'(bl1), 64'(1));
      if (dx1 == 10'd0 && dy1 == 10'd12) chk("blank_y12", 64'(bl1), 64'(0));
      if (k == 800) begin
        chk("wrap_x", 64'(dx0), 64'(0));
        chk("wrap_y", 64'(dy0), 64'(1));
      end
    end

    chk("x656_cycle", 64'(x656), 64'(656));
    chk("hs_low_cnt", 64'(hs_low), 64'(96));
    chk("hs_delay", 64'(hsf - x656), 64'(2));
    chk("hs_low_small", 64'(hs_low_s), 64'(4));
    chk("vs_low_cnt", 64'(vs_low), 64'(50));
    chk("vs_delay", 64'(vsf - y14), 64'(3));
    chk("blank_cnt", 64'(blank_cnt), 64'(192));
    chk("fs_count", 64'(fs_cnt), 64'(2));
    chk("fs_first", 64'(fs_first), 64'(475));
    chk("fs_spacing", 64'(fs_second - fs_first), 64'(475));

    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      if (dx1 == 10'd10 && dy1 == 10'd8) found = 1'b1;
      else step();
    end
    chk("reach_10_8", 64'(found), 64'(1));

    #5;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_small_reset("async_rst");
    @(posedge vga_clk);
    @(negedge vga_clk);
    chk_small_reset("rst_hold");

    reset_n = 1'b1;
    repeat (3 * 475 + 5) step();
    chk("post_rst_x", 64'(dx1), 64'(5));
    chk("post_rst_y", 64'(dy1), 64'(0));
    chk("fc_3_wraps", 64'(fc1), CNT_EN ? 64'(3) : 64'(0));
    chk("fc_dflt", 64'(fc0), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
